reg_to_axil: RTL and testbench
==============================

Name: reg_to_axil

Overview:
- Master-side counterpart of the AXI-Lite-to-register bridge.
- Converts a simple register read/write request interface into AXI-Lite master transactions.
- Used by on-chip control logic (DFX/tandem sequencers, CSR initialisers) to reach AXI-Lite slaves through the interconnect.
- One outstanding transaction. AW and W are issued in the same cycle. Responses are returned to the requester.

Parameters:
- ADDR_WIDTH, 32, address width of register and AXI-Lite sides.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- AXPROT, 3'b000, constant driven on awprot/arprot.
- TIMEOUT_CYCLES, 1024, response-wait limit; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- req_ready  out  1  bridge idle; a request is accepted on (wen|ren)&req_ready.
- wen  in  1  write request.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- wbe  in  DATA_WIDTH/8  byte enables.
- wdone  out  1  one-cycle pulse: write complete.
- wresp  out  2  BRESP of the completed write; valid with wdone.
- ren  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- rvalid  out  1  read data valid; held until rdone.
- rdone  in  1  requester consumes the read data.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  RRESP; valid with rvalid.
- m_axil_awvalid/awready/awaddr/awprot  AXI-Lite write address channel, master side.
- m_axil_wvalid/wready/wdata/wstrb  AXI-Lite write data channel.
- m_axil_bvalid/bready/bresp  AXI-Lite write response channel.
- m_axil_arvalid/arready/araddr/arprot  AXI-Lite read address channel.
- m_axil_rvalid/rready/rdata/rresp  AXI-Lite read data channel.

Behaviour:
- Reset (areset=1 at a clock edge), from the next cycle:
  - State = IDLE; req_ready=1.
  - All m_axil_*valid and *ready = 0.
  - wdone=0, rvalid=0; wresp, rresp, rdata = 0.
- Reset mid-transaction aborts immediately. The downstream slave is expected to be reset together with the bridge.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RD_HOLD. req_ready=1 only in IDLE.
- IDLE:
  - On wen: register waddr, wdata, wbe; go to WR_REQ.
  - Otherwise on ren: register raddr; go to RD_REQ.
  - wen and ren in the same cycle: the write wins and ren is ignored. The requester must re-present the read.
- WR_REQ:
  - awvalid and wvalid both assert in the first WR_REQ cycle (1 cycle after acceptance).
  - Each deasserts independently in the cycle after its own handshake; awaddr/wdata/wstrb stay stable until then.
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: capture bresp into wresp, pulse wdone for 1 cycle, return to IDLE.
  - req_ready rises in the same cycle as wdone.
- Best-case write: accept at T0; aw/w handshake at T1; bvalid at T2; wdone and req_ready at T3.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On m_axil_rvalid: capture rdata and rresp, go to RD_HOLD.
- RD_HOLD:
  - rvalid=1, with rdata/rresp stable.
  - On rdone: rvalid drops the next cycle and the FSM returns to IDLE.
  - rdone while rvalid=0 is ignored.
- No valid deasserts without its handshake, and no address or data changes while its valid is high.
- rready is 0 outside RD_DATA; bready is 0 outside WR_RESP.
- SLVERR/DECERR responses are passed through unchanged. The bridge does not retry.

Optional Feature:
- Macro: REG_TO_AXIL_TIMEOUT_EN.
- Enabled:
  - A counter, cleared on entry to WR_RESP/RD_DATA, increments each cycle spent in those states.
  - Reaching TIMEOUT_CYCLES-1 without bvalid/rvalid completes the transaction locally.
  - Write timeout: wdone pulses with wresp=2'b10.
  - Read timeout: go to RD_HOLD with rdata all ones and rresp=2'b10.
  - bready/rready drop on timeout. A late response is never accepted.
  - Timeout is never applied in WR_REQ/RD_REQ, to preserve AXI valid stability.
- Disabled: no counter; the bridge waits indefinitely.

Decomposition:
- Package reg_to_axil_pkg:
  - state enum.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - timeout read-data fill constant.
- Single module, no sub-modules. The timeout counter is small enough to stay inline.

Test Plan:
- Write with awready=wready=bvalid tied high, wen waddr=0x10 wdata=0xA5A5_0001 wbe=0xF → AW and W handshake at T1, bready at T2, wdone at T3 with wresp=00; req_ready back high at T3.
- Write where wready is delayed 3 cycles after awready → awvalid drops after its handshake, wvalid stays high until its own handshake, then exactly one wdone.
- Read raddr=0x20, slave answers rdata=0x1234_5678 rresp=00 after 2 cycles → rvalid held with data stable through 4 idle cycles until rdone, then rvalid drops and req_ready rises.
- wen and ren together in IDLE → only the write is issued; arvalid stays 0; ren is re-presented afterwards and completes.
- Slave returns bresp=2'b10 → wresp=10; the next read proceeds normally.
- With REG_TO_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts rvalid → after 16 cycles in RD_DATA, rvalid=1, rdata all ones, rresp=10, rready=0.

Source files
------------

// File: rtl/reg_to_axil_pkg.sv
// -----------------------------------------------------------------------------
// reg_to_axil_pkg
// Shared types and constants for the register-request to AXI-Lite master
// bridge (reg_to_axil).
//   state_e          : bridge FSM state encoding (also driven on the debug port)
//   RESP_*           : AXI-Lite response codes
//   RD_TIMEOUT_FILL  : read data returned when a read times out locally
// -----------------------------------------------------------------------------
package reg_to_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RD_HOLD = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for the largest supported DATA_WIDTH; sliced by the user.
    localparam logic [63:0] RD_TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : reg_to_axil_pkg

// File: rtl/reg_to_axil.sv
// -----------------------------------------------------------------------------
// reg_to_axil
// Converts a simple register read/write request interface into AXI-Lite
// master transactions. One transaction outstanding at a time; AW and W are
// presented in the same cycle. Responses are handed back to the requester.
//
// Optional feature macro: REG_TO_AXIL_TIMEOUT_EN
//   When defined, a response-wait counter completes a write (wresp=SLVERR) or
//   a read (rdata all ones, rresp=SLVERR) locally after TIMEOUT_CYCLES cycles
//   in WR_RESP/RD_DATA. When undefined the bridge waits indefinitely.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   req_ready           bridge idle; request accepted on (wen|ren)&req_ready
//   wen/waddr/wdata/wbe write request (write wins over a simultaneous read)
//   wdone/wresp         one-cycle completion pulse with BRESP
//   ren/raddr           read request
//   rvalid/rdata/rresp  read result, held until rdone
//   rdone               requester consumes read result
//   m_axil_*            AXI-Lite master channels AW, W, B, AR, R
//   dbg_state_o         current FSM state
//
// Handshake semantics: a transfer happens on any rising clock edge where
// valid and ready are both high. Once valid is raised it stays high, with its
// payload stable, until that edge; it drops in the following cycle. Ready is
// asserted only while the bridge is able to take the response.
// -----------------------------------------------------------------------------
module reg_to_axil
    import reg_to_axil_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [2:0]  AXPROT         = 3'b000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,

    output logic                      req_ready,
    input  logic                      wen,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wbe,
    output logic                      wdone,
    output logic [1:0]                wresp,
    input  logic                      ren,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    output logic                      rvalid,
    input  logic                      rdone,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,

    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    input  logic [1:0]                m_axil_bresp,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,

    output state_e                    dbg_state_o
);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("reg_to_axil: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("reg_to_axil: TIMEOUT_CYCLES must be at least 2");
    end

    state_e                    state_q,  state_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,  wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q,  wstrb_d;
    logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
    // AW/W handshakes can complete in different cycles; remember each one.
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q,  w_done_d;
    logic                      wdone_q,  wdone_d;
    logic [1:0]                wresp_q,  wresp_d;
    logic [DATA_WIDTH-1:0]     rdata_q,  rdata_d;
    logic [1:0]                rresp_q,  rresp_d;

`ifdef REG_TO_AXIL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    logic aw_hs;
    logic w_hs;

    // Outputs are decoded from registered state only.
    assign req_ready      = (state_q == ST_IDLE);
    assign m_axil_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_axil_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_axil_bready  = (state_q == ST_WR_RESP);
    assign m_axil_arvalid = (state_q == ST_RD_REQ);
    assign m_axil_rready  = (state_q == ST_RD_DATA);
    assign rvalid         = (state_q == ST_RD_HOLD);
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_awprot  = AXPROT;
    assign m_axil_arprot  = AXPROT;
    assign wdone          = wdone_q;
    assign wresp          = wresp_q;
    assign rdata          = rdata_q;
    assign rresp          = rresp_q;
    assign dbg_state_o    = state_q;

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid  && m_axil_wready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdone_q   <= 1'b0;
            wresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef REG_TO_AXIL_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdone_q   <= wdone_d;
            wresp_q   <= wresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef REG_TO_AXIL_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wdone_d   = 1'b0;
        wresp_d   = wresp_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
`ifdef REG_TO_AXIL_TIMEOUT_EN
        timer_d   = timer_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Write has priority; a simultaneous read is dropped.
                if (wen) begin
                    awaddr_d  = waddr;
                    wdata_d   = wdata;
                    wstrb_d   = wbe;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_REQ;
                end else if (ren) begin
                    araddr_d  = raddr;
                    state_d   = ST_RD_REQ;
                end
            end

            ST_WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WR_RESP;
`ifdef REG_TO_AXIL_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end

            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
                    wresp_d = m_axil_bresp;
                    wdone_d = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef REG_TO_AXIL_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    wresp_d = RESP_SLVERR;
                    wdone_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end

            ST_RD_REQ: begin
                if (m_axil_arready) begin
                    state_d = ST_RD_DATA;
`ifdef REG_TO_AXIL_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end

            ST_RD_DATA: begin
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    rresp_d = m_axil_rresp;
                    state_d = ST_RD_HOLD;
                end
`ifdef REG_TO_AXIL_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    rdata_d = RD_TIMEOUT_FILL[DATA_WIDTH-1:0];
                    rresp_d = RESP_SLVERR;
                    state_d = ST_RD_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end

            ST_RD_HOLD: begin
                if (rdone) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule : reg_to_axil

// File: tb/tb_reg_to_axil.sv
// -----------------------------------------------------------------------------
// tb_reg_to_axil
// Directed bench for reg_to_axil. The AXI-Lite slave side is driven by hand
// from the same sequence as the requester, so every cycle of each transaction
// is pinned against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_reg_to_axil;
    import reg_to_axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // clock / reset
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    // requester side
    logic            req_ready;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wbe;
    logic            wdone;
    logic [1:0]      wresp;
    logic            ren;
    logic [AW-1:0]   raddr;
    logic            rvalid;
    logic            rdone;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    // AXI-Lite side
    logic            awvalid, awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid, wready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic            arvalid, arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            axi_rvalid, rready;
    logic [DW-1:0]   axi_rdata;
    logic [1:0]      axi_rresp;
    state_e          dbg_state;

    int checks = 0;
    int errors = 0;

    reg_to_axil #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXPROT(3'b000), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .req_ready(req_ready), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .wdone(wdone), .wresp(wresp), .ren(ren), .raddr(raddr), .rvalid(rvalid),
        .rdone(rdone), .rdata(rdata), .rresp(rresp),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
        .m_axil_awprot(awprot),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_wdata(axi_wdata),
        .m_axil_wstrb(wstrb),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_bresp(bresp),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot),
        .m_axil_rvalid(axi_rvalid), .m_axil_rready(rready), .m_axil_rdata(axi_rdata),
        .m_axil_rresp(axi_rresp),
        .dbg_state_o(dbg_state)
    );

    // driver tasks
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wen = 0; waddr = '0; wdata = '0; wbe = '0; ren = 0; raddr = '0; rdone = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 2'b00;
    endtask

    initial begin
        areset = 1;
        idle_inputs();
        step();
        step();
        // ---- reset state
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
        chk("rst_readies", {bready, rready}, 2'b00);
        chk("rst_wdone_rvalid", {wdone, rvalid}, 2'b00);
        chk("rst_data", {wresp, rresp, rdata}, 36'h0);
        chk("rst_state", dbg_state, ST_IDLE);
        areset = 0;
        step();

        // ---- rdone while idle is ignored
        rdone = 1;
        step();
        chk("rdone_idle_rdy", req_ready, 1);
        chk("rdone_idle_rvalid", rvalid, 0);
        rdone = 0;

        // ---- best-case write
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        wen = 1; waddr = 32'h10; wdata = 32'hA5A5_0001; wbe = 4'hF;
        step();                                         // T1
        wen = 0;
        chk("w1_t1_valids", {awvalid, wvalid}, 2'b11);
        chk("w1_t1_addr", awaddr, 32'h10);
        chk("w1_t1_data", {axi_wdata, wstrb}, {32'hA5A5_0001, 4'hF});
        chk("w1_t1_prot", {awprot, arprot}, 6'b0);
        chk("w1_t1_rdy", req_ready, 0);
        step();                                         // T2
        chk("w1_t2_valids", {awvalid, wvalid}, 2'b00);
        chk("w1_t2_bready", bready, 1);
        chk("w1_t2_wdone", wdone, 0);
        step();                                         // T3
        chk("w1_t3_wdone", wdone, 1);
        chk("w1_t3_wresp", wresp, 2'b00);
        chk("w1_t3_rdy", req_ready, 1);
        chk("w1_t3_bready", bready, 0);
        idle_inputs();
        step();
        chk("w1_t4_wdone", wdone, 0);

        // ---- write with W handshake 3 cycles after AW
        awready = 1; wready = 0;
        wen = 1; waddr = 32'h44; wdata = 32'hDEAD_BEEF; wbe = 4'h3;
        step();                                         // T1: AW handshakes
        wen = 0;
        chk("w2_t1_valids", {awvalid, wvalid}, 2'b11);
        step();                                         // T2
        chk("w2_t2_valids", {awvalid, wvalid}, 2'b01);
        step();                                         // T3
        chk("w2_t3_valids", {awvalid, wvalid}, 2'b01);
        chk("w2_t3_data", {axi_wdata, wstrb}, {32'hDEAD_BEEF, 4'h3});
        step();                                         // T4: W handshakes
        chk("w2_t4_wvalid", wvalid, 1);
        chk("w2_t4_bready", bready, 0);
        wready = 1;
        step();                                         // T5
        wready = 0;
        chk("w2_t5_wvalid", wvalid, 0);
        chk("w2_t5_bready", bready, 1);
        chk("w2_t5_wdone", wdone, 0);
        bvalid = 1;
        step();                                         // T6
        bvalid = 0;
        chk("w2_t6_wdone", wdone, 1);
        step();                                         // T7
        chk("w2_t7_wdone", wdone, 0);
        chk("w2_t7_rdy", req_ready, 1);
        idle_inputs();

        // ---- read, slave answers after 2 cycles, requester holds 4 cycles
        arready = 1;
        ren = 1; raddr = 32'h20;
        step();                                         // T1
        ren = 0;
        chk("r1_t1_arvalid", arvalid, 1);
        chk("r1_t1_araddr", araddr, 32'h20);
        chk("r1_t1_rready", rready, 0);
        step();                                         // T2: RD_DATA
        arready = 0;
        chk("r1_t2_arvalid", arvalid, 0);
        chk("r1_t2_rready", rready, 1);
        step();                                         // T3
        axi_rvalid = 1; axi_rdata = 32'h1234_5678; axi_rresp = 2'b00;
        step();                                         // T4: RD_HOLD
        axi_rvalid = 0; axi_rdata = 32'h0BAD_0BAD; axi_rresp = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("r1_hold_rvalid", rvalid, 1);
            chk("r1_hold_rdata", {rdata, rresp}, {32'h1234_5678, 2'b00});
            chk("r1_hold_rready", rready, 0);
            chk("r1_hold_rdy", req_ready, 0);
            step();
        end
        rdone = 1;
        chk("r1_rdone_rvalid", rvalid, 1);
        step();
        rdone = 0;
        chk("r1_done_rvalid", rvalid, 0);
        chk("r1_done_rdy", req_ready, 1);
        idle_inputs();

        // ---- simultaneous wen and ren: write wins, read re-presented later
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00; arready = 1;
        wen = 1; waddr = 32'h30; wdata = 32'h0000_0030; wbe = 4'hF;
        ren = 1; raddr = 32'h40;
        step();                                         // T1
        wen = 0; ren = 0;
        chk("wr_t1_valids", {awvalid, wvalid, arvalid}, 3'b110);
        chk("wr_t1_addr", awaddr, 32'h30);
        step();                                         // T2
        chk("wr_t2_arvalid", arvalid, 0);
        step();                                         // T3
        chk("wr_t3_wdone", wdone, 1);
        chk("wr_t3_arvalid", arvalid, 0);
        bvalid = 0;
        ren = 1; raddr = 32'h40;
        step();
        ren = 0;
        chk("wr_rd_arvalid", arvalid, 1);
        chk("wr_rd_araddr", araddr, 32'h40);
        step();
        axi_rvalid = 1; axi_rdata = 32'hCAFE_F00D; axi_rresp = 2'b01;
        step();
        axi_rvalid = 0;
        chk("wr_rd_rvalid", rvalid, 1);
        chk("wr_rd_rdata", {rdata, rresp}, {32'hCAFE_F00D, 2'b01});
        rdone = 1;
        step();
        rdone = 0;
        chk("wr_rd_done", {rvalid, req_ready}, 2'b01);
        idle_inputs();

        // ---- SLVERR write response, then a normal read
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
        wen = 1; waddr = 32'h50; wdata = 32'h5555_AAAA; wbe = 4'h1;
        step();
        wen = 0;
        step();
        step();
        chk("err_wdone", wdone, 1);
        chk("err_wresp", wresp, 2'b10);
        idle_inputs();
        arready = 1; ren = 1; raddr = 32'h60;
        step();
        ren = 0;
        chk("err_rd_araddr", {arvalid, araddr}, {1'b1, 32'h60});
        step();
        axi_rvalid = 1; axi_rdata = 32'h0000_0060; axi_rresp = 2'b00;
        step();
        axi_rvalid = 0;
        chk("err_rd_rdata", {rvalid, rdata, rresp}, {1'b1, 32'h0000_0060, 2'b00});
        rdone = 1;
        step();
        rdone = 0;
        chk("err_rd_done", {rvalid, req_ready}, 2'b01);
        idle_inputs();

        // ---- reset in the middle of a write aborts it
        wen = 1; waddr = 32'h70; wdata = 32'h7; wbe = 4'hF;
        step();
        wen = 0;
        chk("abort_pre", {awvalid, wvalid}, 2'b11);
        areset = 1;
        step();
        areset = 0;
        chk("abort_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("abort_rdy", req_ready, 1);
        step();
        chk("abort_idle", {req_ready, wdone}, 2'b10);

`ifdef REG_TO_AXIL_TIMEOUT_EN
        // ---- read timeout: slave never returns data
        idle_inputs();
        arready = 1; ren = 1; raddr = 32'h80;
        step();
        ren = 0;
        chk("to_arvalid", arvalid, 1);
        step();                                         // first RD_DATA cycle
        arready = 0;
        chk("to_rready0", rready, 1);
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_wait_rvalid", {rvalid, rready}, 2'b01);
        end
        step();
        chk("to_rvalid", rvalid, 1);
        chk("to_rdata", {rdata, rresp}, {32'hFFFF_FFFF, 2'b10});
        chk("to_rready", rready, 0);
        rdone = 1;
        step();
        rdone = 0;
        chk("to_done", {rvalid, req_ready}, 2'b01);
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_to_axil
